// File: rtl/dmem_responder.sv
// dmem_responder: data-memory slave for the core's memory stage.
//
// Accepts one load/store at a time over a valid/ready handshake. Waits
// LATENCY cycles, then issues a one-cycle resp_valid pulse. Stores commit
// on the edge that enters RESP and only the strobed bytes change. A new
// request may be accepted in the RESP cycle, so back-to-back traffic has
// no idle bubble.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready request handshake
//   req_we              1 = store, 0 = load
//   req_addr            word address
//   req_wdata/req_wstrb store data and byte-lane enables
//   resp_valid          one-cycle response pulse
//   resp_rdata          load data (0 for stores), held until next response
//   resp_err            out-of-range flag, qualified by resp_valid
//   busy                request outstanding, response not yet issued
//
// Build option
//   DMEM_RANGE_CHECK_EN  defined: addresses >= DEPTH skip the write and
//                        respond with rdata=0, err=1. Undefined: the
//                        address wraps onto its low index bits and
//                        resp_err is tied low.
module dmem_responder #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2     // 0..15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = XLEN / 8;
  localparam logic [3:0] LAT4 = 4'(LATENCY);
  localparam bit ZERO_LAT = (LATENCY == 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, stateNext;
  logic [3:0]        cnt, cntNext;
  logic              capWe;
  logic [XLEN-1:0]   capAddr, capWdata;
  logic [NB-1:0]     capWstrb;
  logic [XLEN-1:0]   mem [DEPTH];

  logic              accept, enterResp, fromCap;
  logic              effWe;
  logic [XLEN-1:0]   effAddr, effWdata;
  logic [NB-1:0]     effWstrb;
  logic [AW-1:0]     idx;
  logic              inRange;
  logic [XLEN-1:0]   merged;

  assign req_ready  = (state != WAIT);
  assign busy       = (state == WAIT);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // RESP is entered either from WAIT when the count expires, or straight
  // from an accept when there are no wait states.
  assign enterResp = ((state == WAIT) && (cnt == 4'd1)) || (accept && ZERO_LAT);

  // Coming out of WAIT the captured request is used; on a zero-latency
  // accept the live request is used, since the capture regs load on the
  // same edge.
  assign fromCap  = (state == WAIT);
  assign effWe    = fromCap ? capWe    : req_we;
  assign effAddr  = fromCap ? capAddr  : req_addr;
  assign effWdata = fromCap ? capWdata : req_wdata;
  assign effWstrb = fromCap ? capWstrb : req_wstrb;

  // Low address bits index the array; DEPTH is expected to be a power of 2.
  assign idx = effAddr[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign inRange = (effAddr < XLEN'(DEPTH));
`else
  assign inRange = 1'b1;
`endif

  always_comb begin
    merged = mem[idx];
    for (int b = 0; b < NB; b++)
      if (effWstrb[b]) merged[8*b +: 8] = effWdata[8*b +: 8];
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      IDLE, RESP: begin
        stateNext = IDLE;
        if (accept) begin
          cntNext   = LAT4;
          stateNext = ZERO_LAT ? RESP : WAIT;
        end
      end
      WAIT: begin
        cntNext = cnt - 4'd1;
        if (cnt == 4'd1) stateNext = RESP;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Array is not reset. Reset forces IDLE asynchronously, which removes
  // the WAIT->RESP commit path, so a dropped request never writes.
  always_ff @(posedge clk)
    if (enterResp && effWe && inRange) mem[idx] <= merged;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      capWe      <= 1'b0;
      capAddr    <= '0;
      capWdata   <= '0;
      capWstrb   <= '0;
      resp_rdata <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      if (accept) begin
        capWe    <= req_we;
        capAddr  <= req_addr;
        capWdata <= req_wdata;
        capWstrb <= req_wstrb;
      end
      // Read data is taken on the RESP-entry edge and held afterwards.
      if (enterResp) resp_rdata <= (effWe || !inRange) ? '0 : mem[idx];
    end
  end

`ifdef DMEM_RANGE_CHECK_EN
  logic errReg;
  always_ff @(posedge clk or posedge reset)
    if (reset)          errReg <= 1'b0;
    else if (enterResp) errReg <= !inRange;
  assign resp_err = errReg;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int XLEN  = 32;
  localparam int DEPTH = 256;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  // main instance, LATENCY=2
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  // zero-latency instance
  logic        vZ = 1'b0, weZ = 1'b0;
  logic [31:0] addrZ = '0, wdataZ = '0;
  logic [3:0]  strbZ = '0;
  logic        readyZ, respZ, errZ, busyZ;
  logic [31:0] rdataZ;

  dmem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .busy(busy)
  );

  dmem_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .LATENCY(0)) dutZ (
    .clk(clk), .reset(reset),
    .req_valid(vZ), .req_ready(readyZ), .req_we(weZ),
    .req_addr(addrZ), .req_wdata(wdataZ), .req_wstrb(strbZ),
    .resp_valid(respZ), .resp_rdata(rdataZ), .resp_err(errZ),
    .busy(busyZ)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        q[$];
  logic [31:0] refMem [DEPTH];
  logic [31:0] lastRdata = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request until accepted; the reference model updates at
  // acceptance and the expected response goes on the scoreboard.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input bit apply, output int acc);
    exp_t e;
    bit   oob;
    int   idx;
    int   n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
    n = 0;
    while (!req_ready && n < 64) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", {63'd0, req_ready}, 64'd1);
      req_valid = 1'b0;
      acc = cyc;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0;
`ifdef DMEM_RANGE_CHECK_EN
    oob = (addr >= DEPTH);
`else
    oob = 1'b0;
`endif
    idx   = int'(addr % DEPTH);
    e.err = oob;
    e.due = acc + LAT;
    if (oob) e.rdata = '0;
    else if (we) begin
      e.rdata = '0;
      if (apply)
        for (int b = 0; b < 4; b++)
          if (strb[b]) refMem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else e.rdata = refMem[idx];
    q.push_back(e);
  endtask

  // Monitor: checks busy/ready against outstanding work, pops on each
  // response and checks its timing, data and error flag.
  always @(negedge clk) begin
    bit   busyE;
    exp_t e;
    busyE = (q.size() > 0) && (q[0].due > cyc);
    chk("busy", {63'd0, busy}, {63'd0, busyE});
    chk("req_ready", {63'd0, req_ready}, {63'd0, !busyE});
    if (q.size() > 0 && q[0].due < cyc) begin
      chk("resp_late", 64'(cyc), 64'(q[0].due));
      e = q.pop_front();
    end
    if (resp_valid) begin
      if (q.size() == 0) chk("resp_unexpected", {63'd0, resp_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("resp_cycle", 64'(cyc), 64'(e.due));
        chk("resp_rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
        chk("resp_err", {63'd0, resp_err}, {63'd0, e.err});
      end
      lastRdata = resp_rdata;
    end else begin
      chk("rdata_hold", {32'd0, resp_rdata}, {32'd0, lastRdata});
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int acc, a1, a2, n;
    // reset state
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_rdata", {32'd0, resp_rdata}, 64'd0);
    chk("rst_err", {63'd0, resp_err}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;

    // give every word a known value
    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i), $urandom, 4'hF, 1'b1, acc);

    // full store / load, byte strobe, zero strobe
    issue(1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 1'b1, acc);
    issue(1'b0, 32'd5, 32'h0, 4'h0, 1'b1, acc);
    issue(1'b1, 32'd5, 32'h000000AA, 4'b0001, 1'b1, acc);
    issue(1'b0, 32'd5, 32'h0, 4'h0, 1'b1, acc);
    issue(1'b1, 32'd5, 32'h000000AA, 4'b0000, 1'b1, acc);
    issue(1'b0, 32'd5, 32'h0, 4'h0, 1'b1, acc);

    // back-to-back store then load of the same word
    issue(1'b1, 32'd7, 32'h12345678, 4'hF, 1'b1, a1);
    issue(1'b0, 32'd7, 32'h0, 4'h0, 1'b1, a2);
    chk("b2b_gap", 64'(a2 - a1), 64'(LAT + 1));

    // reset in WAIT drops the store
    issue(1'b1, 32'd9, 32'h55, 4'hF, 1'b0, acc);
    @(negedge clk); #2;
    reset = 1'b1;
    q.delete();
    lastRdata = '0;
    #1;
    chk("rstwait_busy", {63'd0, busy}, 64'd0);
    chk("rstwait_valid", {63'd0, resp_valid}, 64'd0);
    chk("rstwait_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    issue(1'b0, 32'd9, 32'h0, 4'h0, 1'b1, acc);

    // reset in RESP keeps the committed store
    issue(1'b1, 32'd20, 32'hA5A5C3C3, 4'hF, 1'b1, acc);
    @(negedge clk);
    n = 0;
    while (cyc < acc + LAT && n < 32) begin @(negedge clk); n++; end
    #2;
    reset = 1'b1;
    lastRdata = '0;
    #1;
    chk("rstresp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rstresp_rdata", {32'd0, resp_rdata}, 64'd0);
    @(posedge clk);
    @(negedge clk); #2 reset = 1'b0;
    issue(1'b0, 32'd20, 32'h0, 4'h0, 1'b1, acc);

    // address == DEPTH
    issue(1'b1, 32'(DEPTH), 32'h11, 4'hF, 1'b1, acc);
    issue(1'b0, 32'd0, 32'h0, 4'h0, 1'b1, acc);
    issue(1'b0, 32'(DEPTH), 32'h0, 4'h0, 1'b1, acc);

    // random traffic with idle gaps
    repeat (300) begin
      logic [31:0] ad;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      ad = ($urandom_range(0, 9) == 0) ? 32'(DEPTH + $urandom_range(0, 15))
                                       : 32'($urandom_range(0, DEPTH - 1));
      issue(1'($urandom), ad, $urandom, 4'($urandom), 1'b1, acc);
    end

    n = 0;
    while (q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", 64'(q.size()), 64'd0);

    // zero-latency instance: response in the cycle after accept, never busy
    @(negedge clk);
    vZ = 1'b1; weZ = 1'b1; addrZ = 32'd3; wdataZ = 32'hCAFEF00D; strbZ = 4'hF;
    chk("z_ready", {63'd0, readyZ}, 64'd1);
    @(posedge clk); #1;
    chk("z_st_valid", {63'd0, respZ}, 64'd1);
    chk("z_st_rdata", {32'd0, rdataZ}, 64'd0);
    chk("z_st_busy", {63'd0, busyZ}, 64'd0);
    weZ = 1'b0; wdataZ = 32'h0;
    @(posedge clk); #1;
    chk("z_ld_valid", {63'd0, respZ}, 64'd1);
    chk("z_ld_rdata", {32'd0, rdataZ}, {32'd0, 32'hCAFEF00D});
    chk("z_ld_busy", {63'd0, busyZ}, 64'd0);
    vZ = 1'b0;
    @(posedge clk); #1;
    chk("z_idle_valid", {63'd0, respZ}, 64'd0);
    chk("z_hold_rdata", {32'd0, rdataZ}, {32'd0, 32'hCAFEF00D});

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
